// File: rtl/inv_add_round_key_if.sv
// ============================================================================
// Module      : inv_add_round_key_if
// Description : Bus bundle for the decryption AddRoundKey stage: key load port,
//               state input and registered result towards InvMixColumns.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface inv_add_round_key_if;
  logic         key_we;
  logic [3:0]   key_addr;
  logic [127:0] key_data;
  logic         start;
  logic         enable;
  logic [127:0] value;
  logic [127:0] outValue;
  logic         success;
  logic         mix_en;
  logic         last;
  logic         busy;
  logic [3:0]   round;
  logic         key_err;

  modport master (
    output key_we, key_addr, key_data, start, enable, value,
    input  outValue, success, mix_en, last, busy, round, key_err
  );

  modport slave (
    input  key_we, key_addr, key_data, start, enable, value,
    output outValue, success, mix_en, last, busy, round, key_err
  );
endinterface

`default_nettype wire

// File: rtl/inv_add_round_key.sv
// ============================================================================
// Module      : inv_add_round_key
// Description : Decryption AddRoundKey with local NR+1 round-key store and a
//               descending round sequencer feeding InvMixColumns.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module inv_add_round_key #(
  parameter int NR = 10
) (
  input  wire                  clk,
  input  wire                  reset,
  inv_add_round_key_if.slave   bus
);

  localparam logic [3:0] c_NR     = 4'(NR);
  localparam logic [3:0] c_NR_M1  = 4'(NR - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [3:0]     r_ptr;
  logic [3:0]     w_ptr_nxt;
  logic           w_accept;
  logic [3:0]     w_k;
  logic [127:0]   w_key;
  logic           w_key_wr_ok;

  logic [127:0]   r_keys [0:NR];
  logic [127:0]   r_out;
  logic           r_success;
  logic           r_mix_en;
  logic           r_last;
  logic [3:0]     r_round;
  logic           r_key_err;

  // A start always wins: it aborts any block in flight and reloads from key[NR].
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_accept    = 1'b0;
    w_k         = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (bus.enable && bus.start) begin
          w_accept    = 1'b1;
          w_k         = c_NR;
          w_ptr_nxt   = c_NR_M1;
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (bus.enable && bus.start) begin
          w_accept    = 1'b1;
          w_k         = c_NR;
          w_ptr_nxt   = c_NR_M1;
        end else if (bus.enable) begin
          w_accept = 1'b1;
          w_k      = r_ptr;
          if (r_ptr == 4'd0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_ptr_nxt = r_ptr - 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Key read uses the registered store, so a same-cycle write is not visible.
  assign w_key       = r_keys[w_k];
  assign w_key_wr_ok = bus.key_we && (bus.key_addr <= c_NR) && (r_state == S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= 4'd0;
      r_out     <= 128'd0;
      r_success <= 1'b0;
      r_mix_en  <= 1'b0;
      r_last    <= 1'b0;
      r_round   <= 4'd0;
      r_key_err <= 1'b0;
      for (int i = 0; i <= NR; i++) begin
        r_keys[i] <= 128'd0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_success <= w_accept;
      r_mix_en  <= w_accept && (w_k != c_NR) && (w_k != 4'd0);
      r_last    <= w_accept && (w_k == 4'd0);
      r_key_err <= bus.key_we && !w_key_wr_ok;
      if (w_accept) begin
        r_out   <= bus.value ^ w_key;
        r_round <= w_k;
      end
      if (w_key_wr_ok) begin
        r_keys[bus.key_addr] <= bus.key_data;
      end
    end
  end

  assign bus.outValue = r_out;
  assign bus.success  = r_success;
  assign bus.mix_en   = r_mix_en;
  assign bus.last     = r_last;
  assign bus.busy     = (r_state == S_ACTIVE);
  assign bus.round    = r_round;
  assign bus.key_err  = r_key_err;

endmodule

`default_nettype wire

// File: tb/tb_inv_add_round_key.sv
// ============================================================================
// Module      : tb_inv_add_round_key
// Description : Directed self-checking bench for inv_add_round_key.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_inv_add_round_key;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  inv_add_round_key_if bus ();

  inv_add_round_key #(.NR(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on negedge; outputs are sampled 1ns after the posedge.
  task automatic cyc(input logic we, input logic [3:0] addr, input logic [127:0] kd,
                     input logic st, input logic en, input logic [127:0] val);
    @(negedge clk);
    bus.key_we   = we;
    bus.key_addr = addr;
    bus.key_data = kd;
    bus.start    = st;
    bus.enable   = en;
    bus.value    = val;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 128'd0, 1'b0, 1'b0, 128'd0);
  endtask

  logic [7:0]   b;
  logic [127:0] e;

  initial begin
    checks   = 0;
    failures = 0;
    bus.key_we = 1'b0; bus.key_addr = 4'd0; bus.key_data = 128'd0;
    bus.start  = 1'b0; bus.enable   = 1'b0; bus.value    = 128'd0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_out",     bus.outValue, 128'd0);
    chk("rst_success", 128'(bus.success), 128'd0);
    chk("rst_mix",     128'(bus.mix_en), 128'd0);
    chk("rst_last",    128'(bus.last), 128'd0);
    chk("rst_busy",    128'(bus.busy), 128'd0);
    chk("rst_round",   128'(bus.round), 128'd0);
    chk("rst_keyerr",  128'(bus.key_err), 128'd0);
    @(negedge clk);
    reset = 1'b1;

    // FIPS-197 C.1 first decryption round
    cyc(1'b1, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b0, 1'b0, 128'd0);
    chk("c1_wr_noerr", 128'(bus.key_err), 128'd0);
    cyc(1'b0, 4'd0, 128'd0, 1'b1, 1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("c1_out",     bus.outValue, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
    chk("c1_success", 128'(bus.success), 128'd1);
    chk("c1_round",   128'(bus.round), 128'd10);
    chk("c1_mix",     128'(bus.mix_en), 128'd0);
    chk("c1_last",    128'(bus.last), 128'd0);
    chk("c1_busy",    128'(bus.busy), 128'd1);

    // Key write while ACTIVE is rejected
    cyc(1'b1, 4'd5, {128{1'b1}}, 1'b0, 1'b0, 128'd0);
    chk("act_wr_err",     128'(bus.key_err), 128'd1);
    chk("act_wr_nosucc",  128'(bus.success), 128'd0);
    idle();
    chk("act_wr_errdrop", 128'(bus.key_err), 128'd0);
    chk("act_out_hold",   bus.outValue, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
    for (int j = 9; j >= 0; j--) begin
      cyc(1'b0, 4'd0, 128'd0, 1'b0, 1'b1, 128'd0);
      if (j == 5) chk("rej_key5_read", bus.outValue, 128'd0);
    end
    chk("c1_tail_last",  128'(bus.last), 128'd1);
    chk("c1_tail_round", 128'(bus.round), 128'd0);
    chk("c1_tail_busy",  128'(bus.busy), 128'd0);

    // Load key[i] = {16{i}}, then out-of-range address
    for (int i = 0; i <= 10; i++) begin
      b = 8'(i);
      cyc(1'b1, 4'(i), {16{b}}, 1'b0, 1'b0, 128'd0);
    end
    cyc(1'b1, 4'd11, {128{1'b1}}, 1'b0, 1'b0, 128'd0);
    chk("addr11_err", 128'(bus.key_err), 128'd1);
    idle();
    chk("addr11_errdrop", 128'(bus.key_err), 128'd0);

    // Full 11-round sequence, back to back
    for (int j = 0; j <= 10; j++) begin
      cyc(1'b0, 4'd0, 128'd0, (j == 0), 1'b1, 128'd0);
      b = 8'(10 - j);
      e = {16{b}};
      chk("seq_out",     bus.outValue, e);
      chk("seq_round",   128'(bus.round), 128'(b));
      chk("seq_success", 128'(bus.success), 128'd1);
      chk("seq_mix",     128'(bus.mix_en), 128'((j != 0) && (j != 10)));
      chk("seq_last",    128'(bus.last), 128'(j == 10));
      chk("seq_busy",    128'(bus.busy), 128'(j != 10));
    end
    idle();
    chk("seq_post_succ", 128'(bus.success), 128'd0);
    chk("seq_post_last", 128'(bus.last), 128'd0);

    // Ignored enable in IDLE
    cyc(1'b0, 4'd0, 128'd0, 1'b0, 1'b1, {16{8'h3c}});
    chk("ign_success", 128'(bus.success), 128'd0);
    chk("ign_busy",    128'(bus.busy), 128'd0);
    chk("ign_out",     bus.outValue, 128'd0);

    // Restart after 4 rounds
    for (int j = 0; j < 4; j++) begin
      cyc(1'b0, 4'd0, 128'd0, (j == 0), 1'b1, 128'd0);
    end
    chk("rs_pre_round", 128'(bus.round), 128'd7);
    cyc(1'b0, 4'd0, 128'd0, 1'b1, 1'b1, 128'd0);
    chk("rs_round", 128'(bus.round), 128'd10);
    chk("rs_out",   bus.outValue, {16{8'h0a}});
    chk("rs_mix",   128'(bus.mix_en), 128'd0);
    for (int j = 9; j >= 0; j--) begin
      cyc(1'b0, 4'd0, 128'd0, 1'b0, 1'b1, 128'd0);
      b = 8'(j);
      chk("rs_seq_out", bus.outValue, {16{b}});
      chk("rs_seq_mix", 128'(bus.mix_en), 128'(j != 0));
    end
    chk("rs_last", 128'(bus.last), 128'd1);
    chk("rs_busy", 128'(bus.busy), 128'd0);

    // Write with an accepted start from IDLE: lands, but XOR sees the old key
    cyc(1'b1, 4'd10, {16{8'h5a}}, 1'b1, 1'b1, 128'd0);
    chk("rbw_out",   bus.outValue, {16{8'h0a}});
    chk("rbw_noerr", 128'(bus.key_err), 128'd0);
    cyc(1'b0, 4'd0, 128'd0, 1'b1, 1'b1, 128'd0);
    chk("rbw_new_key", bus.outValue, {16{8'h5a}});
    cyc(1'b0, 4'd0, 128'd0, 1'b0, 1'b1, 128'd0);
    chk("rbw_round9", 128'(bus.round), 128'd9);

    // Asynchronous reset between clock edges, mid-block
    @(negedge clk);
    bus.enable = 1'b1; bus.start = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("ar_out",     bus.outValue, 128'd0);
    chk("ar_success", 128'(bus.success), 128'd0);
    chk("ar_busy",    128'(bus.busy), 128'd0);
    chk("ar_round",   128'(bus.round), 128'd0);
    chk("ar_mix",     128'(bus.mix_en), 128'd0);
    bus.enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle();
    chk("ar_nosucc", 128'(bus.success), 128'd0);
    cyc(1'b0, 4'd0, 128'd0, 1'b1, 1'b1, {16{8'haa}});
    chk("ar_zero_key", bus.outValue, {16{8'haa}});
    chk("ar_round10",  128'(bus.round), 128'd10);
    chk("ar_busy1",    128'(bus.busy), 128'd1);

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
